// File: rtl/spi_master_crc.sv
// SPI master for 32-bit CRC-protected frames: 24 payload bits plus CRC-8, MSB-first.
// sck is divided from clk; miso is captured at the end of each sck high phase.
module spi_master_crc #(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] CRC_POLY = 8'h1D,
    parameter logic [7:0] CRC_INIT = 8'hFF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [23:0] tx_data,
    output logic        rx_valid,
    output logic [23:0] rx_data,
    output logic        rx_crc_err,
    output logic        busy,
    output logic        sck,
    output logic        csn,
    output logic        mosi,
    input  logic        miso
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [31:0]      tx_sr;
    logic [31:0]      rx_sr;
    logic             accept;
    logic             div_done;
    logic             sck_fall;
    logic             mosi_adv;

    function automatic logic [7:0] crc8_24(input logic [23:0] d);
        logic [7:0] c;
        logic       fb;
        c = CRC_INIT;
        for (int i = 23; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
        return c;
    endfunction

    assign tx_ready = (state == ST_IDLE);
    assign busy     = ~tx_ready;
    assign accept   = tx_valid && tx_ready;
    assign div_done = (div_cnt == DIV_LAST);

    // miso is sampled on the edge that drives sck low
    assign sck_fall = (state == ST_SHIFT) && sck && div_done;
    // next frame bit goes out one clk after the falling edge; nothing follows bit 31
    assign mosi_adv = (state == ST_SHIFT) && !sck && (div_cnt == '0) && (bit_cnt != 6'd31);

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sr <= {tx_data, crc8_24(tx_data)};
        end else if (mosi_adv) begin
            tx_sr <= {tx_sr[30:0], 1'b0};
        end
        if (sck_fall) begin
            rx_sr <= {rx_sr[30:0], miso};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sck        <= 1'b0;
            csn        <= 1'b1;
            mosi       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_crc_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (accept) begin
                mosi <= tx_data[23];
            end else if (mosi_adv) begin
                mosi <= tx_sr[30];
            end
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        csn     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_done) begin
                        sck     <= 1'b1;
                        div_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (sck) begin
                            sck <= 1'b0;
                        end else if (bit_cnt == 6'd31) begin
                            state <= ST_HOLD;
                        end else begin
                            sck     <= 1'b1;
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                ST_HOLD: begin
                    if (div_done) begin
                        csn        <= 1'b1;
                        rx_valid   <= 1'b1;
                        rx_data    <= rx_sr[31:8];
                        rx_crc_err <= (crc8_24(rx_sr[31:8]) != rx_sr[7:0]);
                        div_cnt    <= '0;
                        state      <= ST_GAP;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                ST_GAP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: begin
                    sck   <= 1'b0;
                    csn   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_crc.sv
// Directed bench for spi_master_crc with a behavioural SPI slave; CLK_DIV = 2.
module tb_spi_master_crc;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tx_valid = 1'b0;
    logic [23:0] tx_data = '0;
    logic        tx_ready;
    logic        rx_valid;
    logic [23:0] rx_data;
    logic        rx_crc_err;
    logic        busy;
    logic        sck;
    logic        csn;
    logic        mosi;
    logic        miso = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master_crc #(.CLK_DIV(2), .CRC_POLY(8'h1D), .CRC_INIT(8'hFF)) dut (
        .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_crc_err(rx_crc_err), .busy(busy), .sck(sck), .csn(csn),
        .mosi(mosi), .miso(miso)
    );

    // slave: launch reply on sck rise, capture mosi on sck fall
    logic [31:0] reply = '0;
    logic [31:0] mosi_cap = '0;
    int          bitpos = 0;

    always @(posedge sck or posedge csn) begin
        if (csn) begin
            bitpos <= 0;
        end else if (bitpos < 32) begin
            miso   <= reply[31 - bitpos];
            bitpos <= bitpos + 1;
        end
    end

    always @(negedge sck) mosi_cap <= {mosi_cap[30:0], mosi};

    int sck_rises = 0;
    int csn_low   = 0;
    int rxv_cnt   = 0;

    always @(posedge sck) sck_rises <= sck_rises + 1;

    always @(posedge clk) begin
        if (!csn)     csn_low <= csn_low + 1;
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string nm, input logic [23:0] data, input logic [31:0] rep,
                             input logic [31:0] exp_mosi, input logic [23:0] exp_rx,
                             input logic exp_err, input bit poke);
        int n;
        int s0, c0, r0;
        bit seen;
        reply = rep;
        @(negedge clk);
        s0 = sck_rises; c0 = csn_low; r0 = rxv_cnt;
        tx_valid = 1'b1;
        tx_data  = data;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~data;
        check_eq({nm, "_csn_acc"},   32'(csn),      32'd0);
        check_eq({nm, "_busy_acc"},  32'(busy),     32'd1);
        check_eq({nm, "_ready_acc"}, 32'(tx_ready), 32'd0);
        check_eq({nm, "_mosi_first"}, 32'(mosi),    32'(data[23]));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (poke && n == 40) begin
                tx_valid = 1'b1;
                tx_data  = 24'hFFFFFF;
            end
            if (poke && n == 43) tx_valid = 1'b0;
            if (rx_valid) seen = 1'b1;
        end
        check_eq({nm, "_rxv_seen"}, 32'(seen),       32'd1);
        check_eq({nm, "_latency"},  32'(n - 1),      32'd132);
        check_eq({nm, "_rx_data"},  32'(rx_data),    32'(exp_rx));
        check_eq({nm, "_crc_err"},  32'(rx_crc_err), 32'(exp_err));
        check_eq({nm, "_csn_end"},  32'(csn),        32'd1);
        @(negedge clk);
        check_eq({nm, "_rxv_pulse"}, 32'(rx_valid), 32'd0);
        check_eq({nm, "_ready_gap"}, 32'(tx_ready), 32'd0);
        @(negedge clk);
        check_eq({nm, "_ready_back"}, 32'(tx_ready), 32'd1);
        check_eq({nm, "_busy_back"},  32'(busy),     32'd0);
        check_eq({nm, "_sck_pulses"}, 32'(sck_rises - s0), 32'd32);
        check_eq({nm, "_csn_low"},    32'(csn_low - c0),   32'd132);
        check_eq({nm, "_rxv_count"},  32'(rxv_cnt - r0),   32'd1);
        check_eq({nm, "_mosi_stream"}, mosi_cap, exp_mosi);
    endtask

    initial begin
        int n, gap, r0, s0;
        bit seen;

        repeat (3) @(negedge clk);
        check_eq("rst_csn",      32'(csn),        32'd1);
        check_eq("rst_sck",      32'(sck),        32'd0);
        check_eq("rst_mosi",     32'(mosi),       32'd0);
        check_eq("rst_ready",    32'(tx_ready),   32'd1);
        check_eq("rst_busy",     32'(busy),       32'd0);
        check_eq("rst_rxv",      32'(rx_valid),   32'd0);
        check_eq("rst_rx_data",  32'(rx_data),    32'd0);
        check_eq("rst_crc_err",  32'(rx_crc_err), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("zero", 24'h000000, 32'h0000000E, 32'h0000000E, 24'h000000, 1'b0, 1'b1);
        run_frame("badcrc", 24'h000000, 32'h0000000F, 32'h0000000E, 24'h000000, 1'b1, 1'b0);
        run_frame("loop", 24'hA5C33C, 32'hA5C33C56, 32'hA5C33C56, 24'hA5C33C, 1'b0, 1'b0);
        check_eq("loop_crc_byte", 32'(mosi_cap[7:0]), 32'h56);

        // back-to-back with tx_valid held high
        reply = 32'h0000000E;
        @(negedge clk);
        r0 = rxv_cnt;
        tx_valid = 1'b1;
        tx_data  = 24'h000000;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (rx_valid) seen = 1'b1;
        end
        check_eq("b2b_first_rxv", 32'(seen), 32'd1);
        gap = 0;
        while (csn && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check_eq("b2b_csn_gap", 32'(gap), 32'd3);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (rx_valid) seen = 1'b1;
        end
        check_eq("b2b_second_rxv", 32'(seen), 32'd1);
        check_eq("b2b_rx_data", 32'(rx_data), 32'd0);
        check_eq("b2b_crc_err", 32'(rx_crc_err), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("b2b_rxv_count", 32'(rxv_cnt - r0), 32'd2);
        check_eq("b2b_idle", 32'(tx_ready), 32'd1);

        // reset asserted while bit 10 is on the wire
        reply = 32'hFFFFFFFF;
        @(negedge clk);
        s0 = sck_rises;
        r0 = rxv_cnt;
        tx_valid = 1'b1;
        tx_data  = 24'h123456;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        n = 0;
        while ((sck_rises - s0) < 11 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_bit10_reached", 32'(sck_rises - s0), 32'd11);
        check_eq("mid_sck_high", 32'(sck), 32'd1);
        check_eq("mid_csn_low",  32'(csn), 32'd0);
        #1;
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_csn",  32'(csn),  32'd1);
        check_eq("mid_rst_sck",  32'(sck),  32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("mid_no_rxv",  32'(rxv_cnt - r0), 32'd0);
        check_eq("mid_ready",   32'(tx_ready),     32'd1);
        check_eq("mid_rx_data", 32'(rx_data),      32'd0);
        check_eq("mid_csn_idle", 32'(csn),         32'd1);

        run_frame("after_rst", 24'hA5C33C, 32'hA5C33C56, 32'hA5C33C56, 24'hA5C33C, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_crc.md
# spi_master_crc

SPI master that initiates 32-bit frames toward the CRC-protected SPI slave: 24 data bits MSB-first followed by an 8-bit CRC-8 (poly 0x1D, init 0xFF). It runs on the system clock, derives `sck` by division, and shifts `tx_data` out on `mosi` while capturing the slave's 24-bit reply and CRC from `miso`. It sits between the on-chip control logic (valid/ready request side) and the SPI pins.

## Interface
- `CLK_DIV`, default 2: `sck` half-period in `clk` cycles; legal range is ≥2.
- `CRC_POLY`, default 8'h1D: CRC-8 polynomial.
- `CRC_INIT`, default 8'hFF: CRC seed, applied at the start of every frame.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  frame request.
- `tx_ready`  out  1  high in IDLE; a frame is accepted when `tx_valid && tx_ready`.
- `tx_data`  in  24  payload, sampled on accept.
- `rx_valid`  out  1  one-cycle pulse when a received frame is complete.
- `rx_data`  out  24  received payload; holds until the next `rx_valid`.
- `rx_crc_err`  out  1  high when the received CRC does not match; updated with `rx_valid`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sck`  out  1  SPI clock, registered, idles low.
- `csn`  out  1  chip select, registered, active low.
- `mosi`  out  1  master data out, registered.
- `miso`  in  1  slave data in.

## Operation
- **States:** IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- **Reset values:** state=IDLE, `sck`=0, `csn`=1, `mosi`=0, `rx_valid`=0, `rx_data`=0, `rx_crc_err`=0, `busy`=0, `tx_ready`=1 (combinational from IDLE).
- **Accept:**
  - On the accept edge, latch `tx_data`.
  - Compute the tx CRC serially over the 24 bits: fb = c[7]^bit; c = {c[6:0],0} ^ (fb ? CRC_POLY : 0). The result is transmitted as bits 24..31.
  - Set `csn`=0, `mosi`=tx_data[23], and go to SETUP.
- **SETUP:** `CLK_DIV` cycles with `sck`=0.
- **SHIFT:** 32 bits, each `sck` high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - Sample `miso` on the cycle `sck` is driven 1→0, i.e. at the end of the high phase.
  - The slave launches on the `sck` rising edge and samples `mosi` on the falling edge.
  - `mosi` updates to the next frame bit one `clk` cycle after `sck` falls. It does not update after bit 31.
- **Receive CRC:** computed with the same serial rule over received bits 0..23, seeded `CRC_INIT`. Bits 24..31 are the received CRC, MSB-first. `rx_crc_err` = computed ≠ received.
- **HOLD:** `CLK_DIV` cycles with `sck`=0 and `csn`=0.
- **HOLD exit edge:** `csn`=1, `rx_valid`=1 for one cycle, `rx_data` and `rx_crc_err` updated.
- **GAP:** `CLK_DIV` cycles with `csn` high, then IDLE.
- **Counters:** a divider counter (width ≥ clog2(CLK_DIV)) and a 6-bit bit counter (0..31). Both reset at every frame start.
- **Boundary conditions:**
  - `tx_valid` while busy is ignored (`tx_ready`=0). `tx_data` may change after accept.
  - With `tx_valid` held high, frames run back-to-back with `csn` high exactly `CLK_DIV`+1 cycles (GAP plus the IDLE accept cycle).
  - Reset mid-frame: `csn`=1 and `sck`=0 immediately (asynchronously); no `rx_valid`; the partial frame is discarded.
  - `miso` is not synchronized; it is stable because it is launched a full half-period before sampling.

## Timing
- `sck` period = 2·`CLK_DIV` clk cycles; 32 `sck` pulses per frame.
- Accept edge to `csn` low: 0 cycles (registered on the accept edge).
- `csn` low duration = `CLK_DIV`·(2 + 64) cycles; 132 for `CLK_DIV`=2.
- `rx_valid` pulses on the same edge `csn` rises, 132 cycles after accept for `CLK_DIV`=2.
- `tx_ready` returns `CLK_DIV` cycles after `rx_valid`.
- First `sck` rising edge occurs `CLK_DIV` cycles after `csn` falls; last falling edge occurs `CLK_DIV` cycles before `csn` rises.

## Test plan
- **Reset:** `rstn`=0 → `csn`=1, `sck`=0, `mosi`=0, `tx_ready`=1, `busy`=0, `rx_valid`=0.
- **Zero payload:** `tx_data`=0x000000, `CLK_DIV`=2, and a slave model returns 0x0000000E → `mosi` stream = 0x0000000E, 32 `sck` pulses, `csn` low 132 cycles, `rx_data`=0x000000, `rx_crc_err`=0.
- **Bad CRC:** same request, slave returns 0x0000000F → `rx_crc_err`=1, `rx_data`=0x000000.
- **Loopback:** `miso` tied to the slave model echoing `tx_data`=0xA5C33C plus its correct CRC → `rx_data`=0xA5C33C, `rx_crc_err`=0; the `mosi` CRC byte equals the model's CRC.
- **Back-to-back:** `tx_valid` held high for two frames → `csn` high exactly 3 cycles between frames (`CLK_DIV`=2); two `rx_valid` pulses.
- **Reset mid-frame:** `rstn` pulsed low during bit 10 → `csn`=1 and `sck`=0 immediately, no `rx_valid`; the next request completes normally.
